// File: rtl/reg_spill_fill_if.sv
// Command and bus bundle between the control side, reg_file and data memory for reg_spill_fill.
// The slave modport is the engine's view; the master modport is the surrounding system.
interface reg_spill_fill_if #(
    parameter int unsigned pw = 3,
    parameter int unsigned AW = 8
);
    logic          start;
    logic          mode;
    logic [AW-1:0] base_addr;
    logic          busy;
    logic          done;
    logic [pw:0]   rf_addr;
    logic [7:0]    rf_dat_in;
    logic [7:0]    rf_dat_out;
    logic          rf_wr_en;
    logic          rf_mov;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_dat_in;
    logic [7:0]    mem_dat_out;
    logic          mem_wr_en;

    modport slave (
        input  start, mode, base_addr, rf_dat_in, mem_dat_in,
        output busy, done, rf_addr, rf_dat_out, rf_wr_en, rf_mov,
               mem_addr, mem_dat_out, mem_wr_en
    );

    modport master (
        output start, mode, base_addr, rf_dat_in, mem_dat_in,
        input  busy, done, rf_addr, rf_dat_out, rf_wr_en, rf_mov,
               mem_addr, mem_dat_out, mem_wr_en
    );
endinterface

// File: rtl/reg_spill_fill.sv
// Bulk save/restore engine: spills every reg_file register to memory at base+idx,
// or fills reg_file from memory using the movInstr path, one register per cycle.
module reg_spill_fill #(
    parameter int unsigned pw = 3,
    parameter int unsigned AW = 8
) (
    input  logic            clk,
    input  logic            reset,
    reg_spill_fill_if.slave bus
);
    localparam int unsigned IW   = pw + 1;
    localparam int unsigned DW   = 8;
    localparam int unsigned NREG = 2 ** pw;
    localparam logic [IW-1:0] LAST_IDX = IW'(NREG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          mode_q, mode_d;
    logic [AW-1:0] base_q, base_d;

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            base_q  <= base_d;
        end
    end

    // Next state and outputs; outputs depend only on held state and read data.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        mode_d          = mode_q;
        base_d          = base_q;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        bus.rf_addr     = '0;
        bus.rf_dat_out  = '0;
        bus.rf_wr_en    = 1'b0;
        bus.rf_mov      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_dat_out = '0;
        bus.mem_wr_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = XFER;
                    idx_d   = '0;
                    mode_d  = bus.mode;
                    base_d  = bus.base_addr;
                end
            end

            XFER: begin
                bus.busy     = 1'b1;
                bus.rf_addr  = idx_q;
                bus.mem_addr = base_q + AW'(idx_q);
                if (mode_q) begin
                    // movInstr steers the write to addrA instead of core[0]
                    bus.rf_wr_en   = 1'b1;
                    bus.rf_mov     = 1'b1;
                    bus.rf_dat_out = DW'(bus.mem_dat_in);
                end else begin
                    bus.mem_wr_en   = 1'b1;
                    bus.mem_dat_out = DW'(bus.rf_dat_in);
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end

            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                idx_d    = '0;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_reg_spill_fill.sv
// Bench for reg_spill_fill: reg_file/memory models, a scoreboard of expected per-beat strobes,
// a table of save/restore vectors and hand-written corner sequences.
module tb_reg_spill_fill;
    localparam int unsigned PW   = 3;
    localparam int unsigned AW   = 8;
    localparam int unsigned NREG = 8;
    localparam int unsigned OW   = 31;

    logic clk = 1'b0;
    logic reset;

    reg_spill_fill_if #(.pw(PW), .AW(AW)) bus ();

    reg_spill_fill #(.pw(PW), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [7:0] rf_m   [NREG];
    logic [7:0] mem_m  [256];
    logic [7:0] pl_rf  [NREG];
    logic [7:0] pl_mem [256];
    logic       pl_go;
    int         core0_wr = 0;

    assign bus.rf_dat_in  = rf_m[bus.rf_addr[PW-1:0]];
    assign bus.mem_dat_in = mem_m[bus.mem_addr];

    // Environment: reg_file and data memory react to the engine's strobes.
    always @(posedge clk) begin
        if (pl_go) begin
            rf_m  <= pl_rf;
            mem_m <= pl_mem;
        end else begin
            if (bus.mem_wr_en) mem_m[bus.mem_addr] <= bus.mem_dat_out;
            if (bus.rf_wr_en && bus.rf_mov) rf_m[bus.rf_addr[PW-1:0]] <= bus.rf_dat_out;
            if (bus.rf_wr_en && !bus.rf_mov) core0_wr <= core0_wr + 1;
        end
    end

    logic [OW-1:0] sb [$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] obs();
        return {bus.mem_wr_en, bus.rf_wr_en, bus.rf_mov, bus.rf_addr,
                bus.mem_addr, bus.rf_dat_out, bus.mem_dat_out};
    endfunction

    // Every strobe beat is popped against the expected beat pushed at launch.
    always @(negedge clk) begin
        if (!reset && (bus.mem_wr_en || bus.rf_wr_en)) begin
            if (sb.size() == 0) chk("unexpected_strobe", 64'(obs()), 64'h0);
            else                chk("xfer_beat", 64'(obs()), 64'(sb.pop_front()));
        end
    end

    task automatic fill_pl(input logic [7:0] rf_seed, input logic [7:0] mseed,
                           input logic [7:0] mbase);
        for (int i = 0; i < int'(NREG); i++) pl_rf[i] = rf_seed + 8'(i);
        for (int j = 0; j < 256; j++) pl_mem[j] = 8'hEE;
        for (int i = 0; i < int'(NREG); i++) pl_mem[mbase + 8'(i)] = mseed + 8'(i);
        @(negedge clk);
        pl_go = 1'b1;
        @(posedge clk);
        #1 pl_go = 1'b0;
    endtask

    task automatic launch(input logic m, input logic [7:0] b);
        logic [7:0] a;
        @(negedge clk);
        chk("idle_outputs", 64'({bus.busy, bus.done, obs()}), 64'h0);
        for (int i = 0; i < int'(NREG); i++) begin
            a = b + 8'(i);
            if (!m) sb.push_back({3'b100, 4'(i), a, 8'h00, pl_rf[i]});
            else    sb.push_back({3'b011, 4'(i), a, pl_mem[a], 8'h00});
        end
        bus.start = 1'b1;
        bus.mode = m;
        bus.base_addr = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mode = ~m;
        bus.base_addr = ~b;
    endtask

    task automatic run_check(input string nm, input int rep, input int exp_mw, input int exp_rw);
        int n, bc, mw, rw;
        n = 0; bc = 0; mw = 0; rw = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            n++;
            if (bus.busy) bc++;
            if (bus.mem_wr_en) mw++;
            if (bus.rf_wr_en) rw++;
            if (rep != 0 && n == rep) begin
                bus.start = 1'b1;
                bus.mode = 1'b1;
                bus.base_addr = 8'h00;
            end else if (rep != 0 && n == rep + 1) begin
                bus.start = 1'b0;
            end
            if (bus.done) break;
        end
        chk({nm, "_done_latency"}, 64'(n), 64'd9);
        chk({nm, "_busy_cycles"}, 64'(bc), 64'd9);
        chk({nm, "_mem_wr_cycles"}, 64'(mw), 64'(exp_mw));
        chk({nm, "_rf_wr_cycles"}, 64'(rw), 64'(exp_rw));
        chk({nm, "_sb_drained"}, 64'(sb.size()), 64'd0);
    endtask

    typedef struct {
        logic       mode;
        logic [7:0] base;
        logic [7:0] seed;
        int         exp_mw;
        int         exp_rw;
    } vec_t;

    vec_t tv [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        pl_go = 1'b0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.mode = 1'b0;
        bus.base_addr = '0;

        tv[0] = '{mode: 1'b0, base: 8'h40, seed: 8'h10, exp_mw: 8, exp_rw: 0};
        tv[1] = '{mode: 1'b1, base: 8'h80, seed: 8'hA0, exp_mw: 0, exp_rw: 8};
        tv[2] = '{mode: 1'b0, base: 8'hFC, seed: 8'h30, exp_mw: 8, exp_rw: 0};
        tv[3] = '{mode: 1'b1, base: 8'hFE, seed: 8'h5A, exp_mw: 0, exp_rw: 8};

        repeat (2) @(posedge clk);
        #1 chk("reset_outputs", 64'({bus.busy, bus.done, obs()}), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Table: plain save/restore, including address wrap both ways.
        for (int v = 0; v < 4; v++) begin
            if (!tv[v].mode) fill_pl(tv[v].seed, 8'h00, 8'h00);
            else             fill_pl(8'h00, tv[v].seed, tv[v].base);
            launch(tv[v].mode, tv[v].base);
            run_check($sformatf("vec%0d", v), 0, tv[v].exp_mw, tv[v].exp_rw);
            for (int i = 0; i < int'(NREG); i++) begin
                if (!tv[v].mode)
                    chk($sformatf("vec%0d_mem%0d", v, i),
                        64'(mem_m[tv[v].base + 8'(i)]), 64'(tv[v].seed + 8'(i)));
                else
                    chk($sformatf("vec%0d_rf%0d", v, i), 64'(rf_m[i]), 64'(tv[v].seed + 8'(i)));
            end
            if (!tv[v].mode) begin
                chk($sformatf("vec%0d_below", v), 64'(mem_m[tv[v].base - 8'd1]),
                    64'(pl_mem[tv[v].base - 8'd1]));
                chk($sformatf("vec%0d_above", v), 64'(mem_m[tv[v].base + 8'd8]),
                    64'(pl_mem[tv[v].base + 8'd8]));
            end
        end

        // Start re-pulsed mid-transfer with other mode/base must be ignored.
        fill_pl(8'h10, 8'h00, 8'h00);
        launch(1'b0, 8'h40);
        run_check("ignored_start", 3, 8, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ignored_start_idle", 64'({bus.busy, bus.done}), 64'h0);
        end
        for (int i = 0; i < int'(NREG); i++)
            chk("ignored_start_rf", 64'(rf_m[i]), 64'(8'h10 + 8'(i)));

        // Reset after three beats of a save.
        fill_pl(8'h10, 8'h00, 8'h00);
        launch(1'b0, 8'h40);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("reset_async", 64'({bus.busy, bus.done, obs()}), 64'h0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++)
            chk("reset_written", 64'(mem_m[8'h40 + 8'(i)]), 64'(8'h10 + 8'(i)));
        for (int i = 3; i < int'(NREG); i++)
            chk("reset_untouched", 64'(mem_m[8'h40 + 8'(i)]), 64'hEE);
        launch(1'b0, 8'h60);
        run_check("after_reset", 0, 8, 0);
        for (int i = 0; i < int'(NREG); i++)
            chk("after_reset_mem", 64'(mem_m[8'h60 + 8'(i)]), 64'(8'h10 + 8'(i)));

        // Back-to-back: second start in the first IDLE cycle after done.
        fill_pl(8'h20, 8'hC0, 8'h90);
        launch(1'b0, 8'h20);
        run_check("b2b_first", 0, 8, 0);
        launch(1'b1, 8'h90);
        run_check("b2b_second", 0, 0, 8);
        for (int i = 0; i < int'(NREG); i++) begin
            chk("b2b_mem", 64'(mem_m[8'h20 + 8'(i)]), 64'(8'h20 + 8'(i)));
            chk("b2b_rf", 64'(rf_m[i]), 64'(8'hC0 + 8'(i)));
        end

        chk("core0_writes", 64'(core0_wr), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
